// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the i2c transaction arbiter.
// The optional timeout path is enabled with I2C_ARB_TIMEOUT_EN.
package i2c_arb_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;
    localparam int TIMEOUT_W  = 20;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESPOND   = 3'd4
    } arb_state_e;

    // Successor of idx in a ring of n entries.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = IW'(j);
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one i2c_controller between NUM_REQ requesters.
// Define I2C_ARB_TIMEOUT_EN to add the per-transaction abort counter and timeout_o.
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
`ifdef I2C_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1048575
`endif
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ-1:0]      rw_i,
    input  logic [7*NUM_REQ-1:0]    addr_i,
    input  logic [8*NUM_REQ-1:0]    reg_id_i,
    input  logic [8*NUM_REQ-1:0]    wdata_i,
    output logic [NUM_REQ-1:0]      gnt_o,
    output logic [NUM_REQ-1:0]      done_o,
    output logic                    nack_o,
    output logic [7:0]              rdata_o,
    output logic [6:0]              ctl_address_o,
    output logic                    ctl_rw_o,
    output logic [7:0]              ctl_register_id_o,
    output logic [7:0]              ctl_register_value_o,
    output logic                    ctl_execute_o,
    input  logic                    ctl_busy_i,
    input  logic                    ctl_done_i,
    input  logic                    ctl_nack_i,
    input  logic [7:0]              ctl_rdata_i,
`ifdef I2C_ARB_TIMEOUT_EN
    output logic                    timeout_o,
`endif
    output logic [2:0]              dbg_state_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, win_q;
    logic [NUM_REQ-1:0]      gnt_q;
    logic [I2C_ADDR_W-1:0]   addr_q;
    logic                    rw_q;
    logic [I2C_DATA_W-1:0]   reg_q, wdata_q, rdata_q;
    logic                    nack_q;
    logic [NUM_REQ-1:0]      pick_onehot;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_any;
    logic                    waiting;
    logic                    tmo_expire;

    rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
        .req    (req_i),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign waiting = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);

`ifdef I2C_ARB_TIMEOUT_EN
    // k cycles after ISSUE the counter reads k-1, so expiring at TIMEOUT_CYCLES-2
    // places RESPOND exactly TIMEOUT_CYCLES cycles after the execute pulse.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 2);

    logic [TIMEOUT_W-1:0] tmo_cnt_q;
    logic                 tmo_q;

    assign tmo_expire = waiting && !ctl_done_i && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            if (state_q == ISSUE) begin
                tmo_cnt_q <= '0;
            end else if (waiting) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (tmo_expire) begin
                tmo_q <= 1'b1;
            end else if (state_q == RESPOND) begin
                tmo_q <= 1'b0;
            end
        end
    end

    assign timeout_o = (state_q == RESPOND) && tmo_q;
`else
    assign tmo_expire = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (pick_any) state_d = ISSUE;
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                // A done that beats the busy flag still counts as completion.
                if (ctl_done_i)      state_d = RESPOND;
                else if (ctl_busy_i) state_d = WAIT_DONE;
                else if (tmo_expire) state_d = RESPOND;
            end
            WAIT_DONE: if (ctl_done_i || tmo_expire) state_d = RESPOND;
            RESPOND:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Transaction fields are latched at grant so later requester changes are ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            reg_q   <= '0;
            wdata_q <= '0;
            nack_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        gnt_q   <= pick_onehot;
                        win_q   <= pick_idx;
                        rw_q    <= rw_i[pick_idx];
                        addr_q  <= addr_i[pick_idx*I2C_ADDR_W +: I2C_ADDR_W];
                        reg_q   <= reg_id_i[pick_idx*I2C_DATA_W +: I2C_DATA_W];
                        wdata_q <= wdata_i[pick_idx*I2C_DATA_W +: I2C_DATA_W];
                    end
                end
                WAIT_BUSY, WAIT_DONE: begin
                    if (ctl_done_i) begin
                        nack_q  <= ctl_nack_i;
                        rdata_q <= rw_q ? ctl_rdata_i : '0;
                    end else if (tmo_expire) begin
                        nack_q  <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                RESPOND: begin
                    gnt_q   <= '0;
                    nack_q  <= 1'b0;
                    rdata_q <= '0;
                    ptr_q   <= IDX_W'(rr_next(int'(win_q), NUM_REQ));
                end
                default: ;
            endcase
        end
    end

    assign gnt_o                = gnt_q;
    assign done_o               = (state_q == RESPOND) ? gnt_q : '0;
    assign nack_o               = nack_q;
    assign rdata_o              = rdata_q;
    assign ctl_address_o        = addr_q;
    assign ctl_rw_o             = rw_q;
    assign ctl_register_id_o    = reg_q;
    assign ctl_register_value_o = wdata_q;
    assign ctl_execute_o        = (state_q == ISSUE);
    assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed plus randomized bench for i2c_txn_arbiter with a bench-side controller
// model and a round-robin reference model; covers timeout when I2C_ARB_TIMEOUT_EN is set.
module tb_i2c_txn_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_v = '0;
    logic [N-1:0]   rw_v;
    logic [7*N-1:0] addr_v;
    logic [8*N-1:0] reg_v, wd_v;
    logic           ctl_busy = 1'b0, ctl_done = 1'b0, ctl_nack = 1'b0;
    logic [7:0]     ctl_rdata = '0;

    logic [N-1:0]   gnt_o, done_o;
    logic           nack_o, ctl_rw_o, ctl_execute_o;
    logic [7:0]     rdata_o, ctl_register_id_o, ctl_register_value_o;
    logic [6:0]     ctl_address_o;
    logic [2:0]     dbg_state_o;
`ifdef I2C_ARB_TIMEOUT_EN
    logic           timeout_o;
`endif

    logic [6:0] f_addr[N];
    logic [7:0] f_reg[N];
    logic [7:0] f_wd[N];
    logic       f_rw[N];

    logic [3:0] exp_q[$];
    int         model_ptr = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always_comb begin
        addr_v = '0;
        reg_v  = '0;
        wd_v   = '0;
        rw_v   = '0;
        for (int k = 0; k < N; k++) begin
            addr_v[7*k +: 7] = f_addr[k];
            reg_v[8*k +: 8]  = f_reg[k];
            wd_v[8*k +: 8]   = f_wd[k];
            rw_v[k]          = f_rw[k];
        end
    end

    i2c_txn_arbiter #(
        .NUM_REQ(N)
`ifdef I2C_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .req_i                (req_v),
        .rw_i                 (rw_v),
        .addr_i               (addr_v),
        .reg_id_i             (reg_v),
        .wdata_i              (wd_v),
        .gnt_o                (gnt_o),
        .done_o               (done_o),
        .nack_o               (nack_o),
        .rdata_o              (rdata_o),
        .ctl_address_o        (ctl_address_o),
        .ctl_rw_o             (ctl_rw_o),
        .ctl_register_id_o    (ctl_register_id_o),
        .ctl_register_value_o (ctl_register_value_o),
        .ctl_execute_o        (ctl_execute_o),
        .ctl_busy_i           (ctl_busy),
        .ctl_done_i           (ctl_done),
        .ctl_nack_i           (ctl_nack),
        .ctl_rdata_i          (ctl_rdata),
`ifdef I2C_ARB_TIMEOUT_EN
        .timeout_o            (timeout_o),
`endif
        .dbg_state_o          (dbg_state_o)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: set request at the smallest forward distance from the pointer.
    function automatic int exp_winner(input logic [N-1:0] r, input int p);
        int best = -1;
        int bd = N;
        for (int k = 0; k < N; k++) begin
            int d = (k - p + N) % N;
            if (r[k] && d < bd) begin
                bd = d;
                best = k;
            end
        end
        return best;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic randomize_fields();
        for (int k = 0; k < N; k++) begin
            f_addr[k] = 7'($urandom);
            f_reg[k]  = 8'($urandom);
            f_wd[k]   = 8'($urandom);
            f_rw[k]   = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check("rst_gnt", gnt_o, 0);
        check("rst_done", done_o, 0);
        check("rst_exec", ctl_execute_o, 0);
        check("rst_addr", ctl_address_o, 0);
        check("rst_state", dbg_state_o, 0);
        rst = 1'b0;
        model_ptr = 0;
    endtask

    // Called at a negedge where req_v is already presented; the grant must be
    // visible at the next negedge. next_req is applied when done_o is seen.
    task automatic do_txn(input bit nack, input logic [7:0] rd, input int busy_cyc,
                          input bit drop, input logic [N-1:0] next_req);
        int k;
        logic [6:0] sa;
        logic [7:0] sg, sw;
        logic       sr;
        k  = int'(exp_q.pop_front());
        sa = f_addr[k];
        sg = f_reg[k];
        sw = f_wd[k];
        sr = f_rw[k];
        tick();
        check("grant", gnt_o, 32'd1 << k);
        check("exec_pulse", ctl_execute_o, 1);
        check("ctl_addr", ctl_address_o, sa);
        check("ctl_reg", ctl_register_id_o, sg);
        check("ctl_wdata", ctl_register_value_o, sw);
        check("ctl_rw", ctl_rw_o, sr);
        tick();
        check("exec_once", ctl_execute_o, 0);
        if (drop) begin
            req_v[k]  = 1'b0;
            f_addr[k] = 7'($urandom);
            f_reg[k]  = 8'($urandom);
            f_wd[k]   = 8'($urandom);
            f_rw[k]   = ~f_rw[k];
        end
        for (int i = 0; i < busy_cyc; i++) begin
            ctl_busy = 1'b1;
            tick();
        end
        ctl_busy  = 1'b0;
        ctl_done  = 1'b1;
        ctl_nack  = nack;
        ctl_rdata = rd;
        tick();
        ctl_done  = 1'b0;
        ctl_nack  = 1'b0;
        ctl_rdata = 8'($urandom);
        check("done_pulse", done_o, 32'd1 << k);
        check("nack", nack_o, nack);
        check("rdata", rdata_o, sr ? rd : 8'h00);
        check("gnt_held", gnt_o, 32'd1 << k);
        check("ctl_addr_held", ctl_address_o, sa);
        model_ptr = (k + 1) % N;
        req_v = next_req;
        tick();
        check("done_clear", done_o, 0);
        check("gnt_clear", gnt_o, 0);
        check("rdata_clear", rdata_o, 0);
        check("nack_clear", nack_o, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int k4, w, cnt;
        logic [N-1:0] nxt;
        randomize_fields();
        do_reset();

        // Single write from requester 1; controller returns junk rdata on a write.
        f_addr[1] = 7'h40; f_reg[1] = 8'h06; f_wd[1] = 8'h4D; f_rw[1] = 1'b0;
        req_v = 4'b0010;
        exp_q.push_back(4'(exp_winner(req_v, model_ptr)));
        do_txn(1'b0, 8'h77, 2, 1'b0, 4'b0000);

        // Read from requester 3.
        f_rw[3] = 1'b1;
        req_v = 4'b1000;
        exp_q.push_back(4'(exp_winner(req_v, model_ptr)));
        do_txn(1'b0, 8'hA5, 1, 1'b0, 4'b0000);

        // Contention from reset: fixed rotation with one idle cycle between grants.
        do_reset();
        randomize_fields();
        req_v = 4'b1111;
        for (int i = 0; i < 8; i++) exp_q.push_back(4'(i % N));
        for (int i = 0; i < 8; i++)
            do_txn(1'b0, 8'($urandom), 1, 1'b0, (i == 7) ? 4'b0000 : 4'b1111);

        // NACK with mid-transaction drop; the pointer must move past the winner.
        k4 = $urandom_range(0, 2);
        req_v = 4'(1 << k4);
        exp_q.push_back(4'(exp_winner(req_v, model_ptr)));
        do_txn(1'b1, 8'($urandom), 2, 1'b1, 4'((1 << k4) | (1 << (k4 + 1))));
        exp_q.push_back(4'(k4 + 1));
        do_txn(1'b0, 8'($urandom), 1, 1'b0, 4'b0000);

        // Reset while waiting for the controller's done.
        req_v = 4'b0100;
        tick();
        check("abort_gnt", gnt_o, 4'b0100);
        tick();
        ctl_busy = 1'b1;
        tick();
        check("abort_state", dbg_state_o, 3);
        rst = 1'b1;
        req_v = '0;
        tick();
        rst = 1'b0;
        ctl_busy = 1'b0;
        check("abort_gnt0", gnt_o, 0);
        check("abort_done0", done_o, 0);
        check("abort_nack0", nack_o, 0);
        check("abort_rdata0", rdata_o, 0);
        check("abort_ctl0", {ctl_address_o, ctl_rw_o, ctl_register_id_o,
                             ctl_register_value_o, ctl_execute_o}, 0);
        model_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", done_o, 0);
        end
        req_v = 4'b1111;
        exp_q.push_back(4'(exp_winner(req_v, model_ptr)));
        do_txn(1'b0, 8'($urandom), 1, 1'b0, 4'b0000);

        // Randomized traffic against the round-robin model.
        randomize_fields();
        req_v = 4'($urandom_range(1, 15));
        for (int it = 0; it < 12; it++) begin
            w = exp_winner(req_v, model_ptr);
            exp_q.push_back(4'(w));
            nxt = (req_v & ~4'(1 << w)) | 4'($urandom_range(0, 15));
            if (it == 11) nxt = '0;
            else if (nxt == 0) nxt = 4'(1 << $urandom_range(0, 3));
            do_txn(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), nxt);
        end

`ifdef I2C_ARB_TIMEOUT_EN
        // Controller stays busy forever; abort lands 100 cycles after ISSUE.
        req_v = 4'b0001;
        tick();
        check("tmo_exec", ctl_execute_o, 1);
        ctl_busy = 1'b1;
        cnt = 0;
        while (cnt < 200 && done_o == 0) begin
            tick();
            cnt++;
        end
        check("tmo_latency", cnt, 100);
        check("tmo_nack", nack_o, 1);
        check("tmo_flag", timeout_o, 1);
        check("tmo_rdata", rdata_o, 0);
        ctl_busy = 1'b0;
        req_v = '0;
        tick();
        check("tmo_flag_clear", timeout_o, 0);
`else
        cnt = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares one i2c_controller between NUM_REQ requesters, e.g. PWM channel updaters, the init sequencer and the readback logic.
- Arbitrates using round-robin order.
- Latches the winner's transaction fields and pulses the controller's execute input.
- Tracks the controller's busy/done handshake and returns completion status, NACK and read data to the winner.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1048575, clk_i cycles allowed per transaction before abort. Used only with I2C_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  NUM_REQ  per-requester request level. Held until that requester's done_o.
- rw_i  in  NUM_REQ  per-requester read(1)/write(0).
- addr_i  in  7*NUM_REQ  packed target addresses; requester k uses bits [7k+6:7k].
- reg_id_i  in  8*NUM_REQ  packed register ids.
- wdata_i  in  8*NUM_REQ  packed write values.
- gnt_o  out  NUM_REQ  one-hot grant, held for the whole transaction.
- done_o  out  NUM_REQ  one-cycle completion pulse to the winner.
- nack_o  out  1  NACK status, valid while any done_o is high.
- rdata_o  out  8  read data, valid while any done_o is high; 0 for writes.
- ctl_address_o  out  7  address to the controller.
- ctl_rw_o  out  1  rw to the controller.
- ctl_register_id_o  out  8  register id to the controller.
- ctl_register_value_o  out  8  write value to the controller.
- ctl_execute_o  out  1  one-cycle start pulse.
- ctl_busy_i  in  1  controller is mid-transaction.
- ctl_done_i  in  1  controller completion pulse.
- ctl_nack_i  in  1  NACK seen; sampled with ctl_done_i.
- ctl_rdata_i  in  8  read byte; sampled with ctl_done_i.

Behaviour:
- Reset (rst_i high at a clk_i edge) forces all of the following to 0:
  - gnt_o, done_o, nack_o, rdata_o
  - all ctl_* outputs
  - round-robin pointer, which points to requester 0
  - state, which goes to IDLE
- Reset mid-transaction abandons the transaction. No done_o is issued. Resetting the controller is the system's job.
- States: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> RESPOND -> IDLE.
- IDLE:
  - If any req_i bit is set, pick the first set bit at or after the pointer, wrapping at NUM_REQ-1 -> 0.
  - Latch that requester's rw/addr/reg_id/wdata into the ctl_* registers and set its gnt_o bit. Go to ISSUE.
  - Latency: req_i seen at edge N gives gnt_o and ctl fields at N+1.
- ISSUE:
  - ctl_execute_o = 1 for exactly this cycle. Go to WAIT_BUSY.
- WAIT_BUSY:
  - Stay until ctl_busy_i = 1, then go to WAIT_DONE.
  - If ctl_done_i arrives before busy is seen, treat it as completion and go to RESPOND.
- WAIT_DONE:
  - On ctl_done_i, capture ctl_nack_i and ctl_rdata_i, forcing rdata to 0 when rw = 0. Go to RESPOND.
- RESPOND:
  - done_o[winner] = 1, nack_o and rdata_o valid, gnt_o still held, for one cycle.
  - Pointer <= (winner+1) mod NUM_REQ. Go to IDLE.
  - At IDLE entry: gnt_o clears, nack_o and rdata_o return to 0.
- Earliest re-grant is one cycle after RESPOND, so there is always one idle turnaround cycle.
- ctl_* field outputs are stable from grant through RESPOND.
- Input changes after the grant are ignored:
  - a requester dropping req_i still completes and still gets done_o;
  - changing its fields has no effect.
- Simultaneous requests: only one grant at a time. The others wait. Every requester with req_i held is served within NUM_REQ transactions.
- A new req_i rising during a transaction is queued implicitly by its level.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- With it:
  - a 20-bit cycle counter clears on ISSUE and increments in WAIT_BUSY and WAIT_DONE;
  - reaching TIMEOUT_CYCLES forces RESPOND with nack_o = 1 and rdata_o = 0;
  - extra output port timeout_o (1 bit) is high with that done_o.
- Without it: no counter and no timeout_o port. The arbiter waits indefinitely for ctl_done_i.

Decomposition:
- Package i2c_arb_pkg holds:
  - state encoding constants IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_DONE=3, RESPOND=4;
  - I2C_ADDR_W = 7, I2C_DATA_W = 8, TIMEOUT_W = 20.
- One sub-module: rr_pick.
  - Combinational round-robin picker: req vector + pointer -> one-hot winner + index + any.
  - Instantiated once.

Test Plan:
1. Single write: req_i = 4'b0010, addr 7'h40, reg 8'h06, wdata 8'h4D; controller model gives busy, then done with nack 0. Required:
   - gnt_o = 0010 one cycle later;
   - ctl_execute_o one pulse with ctl fields = 40/06/4D;
   - done_o = 0010 for one cycle, nack_o = 0, rdata_o = 0.
2. Read: requester 3, rw = 1, model returns rdata 8'hA5 -> done_o[3] with rdata_o = A5. rdata_o is 0 in the next cycle.
3. Contention: req_i = 4'b1111 held for 8 transactions from reset -> grant order 0, 1, 2, 3, 0, 1, 2, 3, with exactly one idle cycle between grants.
4. NACK and early drop: model returns nack 1 while the requester drops req_i mid-transaction -> done_o still pulses with nack_o = 1, and the pointer advances.
5. Reset mid-transaction: assert rst_i in WAIT_DONE -> next cycle all outputs are 0 and no done_o pulse appears. The next request goes to requester 0 first.
6. With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 100: model never asserts done -> done_o, nack_o = 1 and timeout_o = 1 occur exactly 100 cycles after ISSUE.
